intersection_phase_scheduler: RTL and testbench

Sequences a two-approach intersection (north-south, east-west) plus a shared pedestrian crossing, with one timed phase active at a time. The block owns phase timing, alternation between approaches, vehicle and pedestrian demand latching, all-red clearance and emergency-vehicle preemption. It drives the per-approach lamp outputs directly and exposes the current phase for status logic.

---
 rtl/intersection_phase_scheduler_if.sv | 32 +++
 rtl/intersection_phase_scheduler.sv | 144 ++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_phase_scheduler_if.sv
// Sensor/request inputs and lamp/status outputs of the intersection phase scheduler.
interface intersection_phase_scheduler_if;
  logic       tick;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic       emg_req;
  logic       emg_dir;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       ped_walk;
  logic       emg_active;
  logic [2:0] phase;

  // Controller side: drives the timebase, sensors and requests.
  modport master (
    output tick, ns_car, ew_car, ped_req, emg_req, emg_dir,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  ped_walk, emg_active, phase
  );

  // Scheduler side.
  modport slave (
    input  tick, ns_car, ew_car, ped_req, emg_req, emg_dir,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output ped_walk, emg_active, phase
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection sequencer with pedestrian walk, all-red
// clearance and emergency preemption. Lamps decode directly from state.
module intersection_phase_scheduler #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  intersection_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ns_pend_q, ns_pend_d;
  logic             ew_pend_q, ew_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             last_dir_q, last_dir_d;

  logic   allred_exp, walk_exp, yellow_exp, gmin_ok, gmax_hit;
  logic   opp_pend, cur_pend, sel_dir;
  state_t sel_green, emg_green;

  // Timer expiry qualifiers; gmax_hit uses >= so a released preemption ends on the next tick.
  assign allred_exp = bus.tick && (timer_q == CNT_W'(ALLRED_T - 1));
  assign walk_exp   = bus.tick && (timer_q == CNT_W'(WALK_T - 1));
  assign yellow_exp = bus.tick && (timer_q == CNT_W'(YELLOW_T - 1));
  assign gmin_ok    = bus.tick && (timer_q >= CNT_W'(GREEN_MIN - 1));
  assign gmax_hit   = bus.tick && (timer_q >= CNT_W'(GREEN_MAX - 1));

  // Alternate approaches; stay on the last one only if it alone has demand.
  assign opp_pend  = (last_dir_q == DIR_EW) ? ns_pend_q : ew_pend_q;
  assign cur_pend  = (last_dir_q == DIR_EW) ? ew_pend_q : ns_pend_q;
  assign sel_dir   = (opp_pend || !cur_pend) ? ~last_dir_q : last_dir_q;
  assign sel_green = (sel_dir == DIR_NS) ? NS_GREEN : EW_GREEN;
  assign emg_green = (bus.emg_dir == DIR_NS) ? NS_GREEN : EW_GREEN;

  // State, timer, demand latches and last-served direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ALL_RED;
      timer_q    <= '0;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      last_dir_q <= DIR_EW;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
      last_dir_q <= last_dir_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALL_RED: begin
        if (allred_exp) begin
          if (bus.emg_req)     state_d = emg_green;
          else if (ped_pend_q) state_d = PED_WALK;
          else                 state_d = sel_green;
        end
      end
      PED_WALK: begin
        if (bus.emg_req)   state_d = ALL_RED;
        else if (walk_exp) state_d = sel_green;
      end
      NS_GREEN: begin
        if (bus.emg_req) begin
          if (bus.emg_dir != DIR_NS) state_d = NS_YELLOW;
        end else if ((gmin_ok && (ew_pend_q || ped_pend_q)) || gmax_hit) begin
          state_d = NS_YELLOW;
        end
      end
      EW_GREEN: begin
        if (bus.emg_req) begin
          if (bus.emg_dir != DIR_EW) state_d = EW_YELLOW;
        end else if ((gmin_ok && (ns_pend_q || ped_pend_q)) || gmax_hit) begin
          state_d = EW_YELLOW;
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        if (yellow_exp) state_d = ALL_RED;
      end
      default: state_d = ALL_RED;
    endcase
  end

  // Timer and latch updates; a latch is cleared while, or as, its phase is served.
  always_comb begin
    timer_d    = timer_q;
    last_dir_d = last_dir_q;
    if (state_d != state_q)           timer_d = '0;
    else if (bus.tick && ~&timer_q)   timer_d = timer_q + CNT_W'(1);
    ns_pend_d  = (state_q == NS_GREEN || state_d == NS_GREEN) ? 1'b0 : (ns_pend_q  | bus.ns_car);
    ew_pend_d  = (state_q == EW_GREEN || state_d == EW_GREEN) ? 1'b0 : (ew_pend_q  | bus.ew_car);
    ped_pend_d = (state_q == PED_WALK || state_d == PED_WALK) ? 1'b0 : (ped_pend_q | bus.ped_req);
    if (state_d == NS_GREEN) last_dir_d = DIR_NS;
    if (state_d == EW_GREEN) last_dir_d = DIR_EW;
  end

  // Lamp, walk and status decode.
  always_comb begin
    bus.ns_red    = 1'b1;
    bus.ns_yellow = 1'b0;
    bus.ns_green  = 1'b0;
    bus.ew_red    = 1'b1;
    bus.ew_yellow = 1'b0;
    bus.ew_green  = 1'b0;
    bus.ped_walk  = 1'b0;
    bus.phase     = 3'd0;
    case (state_q)
      NS_GREEN:  begin bus.ns_red = 1'b0; bus.ns_green  = 1'b1; bus.phase = 3'd1; end
      NS_YELLOW: begin bus.ns_red = 1'b0; bus.ns_yellow = 1'b1; bus.phase = 3'd2; end
      EW_GREEN:  begin bus.ew_red = 1'b0; bus.ew_green  = 1'b1; bus.phase = 3'd3; end
      EW_YELLOW: begin bus.ew_red = 1'b0; bus.ew_yellow = 1'b1; bus.phase = 3'd4; end
      PED_WALK:  begin bus.ped_walk = 1'b1; bus.phase = 3'd5; end
      default:   bus.phase = 3'd0;
    endcase
    bus.emg_active = bus.emg_req &&
                     ((state_q == NS_GREEN && bus.emg_dir == DIR_NS) ||
                      (state_q == EW_GREEN && bus.emg_dir == DIR_EW));
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed scenarios plus randomized traffic against a phase-level reference model.
module tb_intersection_phase_scheduler;
  localparam int GMIN = 3;
  localparam int GMAX = 6;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int WALK = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler #(
    .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YEL), .ALLRED_T(AR), .WALK_T(WALK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, ticks spent in it, outstanding demands, last served road.
  int m_ph, m_el, n_ph, n_el;
  bit m_ns, m_ew, m_ped, m_last_ew;
  bit n_ns, n_ew, n_ped, n_last_ew;

  function automatic int pick_road();
    bit waiting_other = m_last_ew ? m_ns : m_ew;
    bit waiting_same  = m_last_ew ? m_ew : m_ns;
    bit go_ew = (waiting_other || !waiting_same) ? !m_last_ew : m_last_ew;
    return go_ew ? 3 : 1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_ns = 0; m_ew = 0; m_ped = 0; m_last_ew = 1;
  endtask

  task automatic model_next();
    bit t = bus.tick;
    int nxt = m_ph;
    case (m_ph)
      0: if (t && m_el == AR - 1)
           nxt = bus.emg_req ? (bus.emg_dir ? 3 : 1) : (m_ped ? 5 : pick_road());
      5: if (bus.emg_req) nxt = 0;
         else if (t && m_el == WALK - 1) nxt = pick_road();
      1, 3: begin
        bit mine_ew = (m_ph == 3);
        bit rival = mine_ew ? m_ns : m_ew;
        if (bus.emg_req) begin
          if (bus.emg_dir != mine_ew) nxt = m_ph + 1;
        end else if (t && ((m_el >= GMIN - 1 && (rival || m_ped)) || m_el >= GMAX - 1))
          nxt = m_ph + 1;
      end
      default: if (t && m_el == YEL - 1) nxt = 0;
    endcase
    n_ph  = nxt;
    n_el  = (nxt != m_ph) ? 0 : ((t && m_el < 255) ? m_el + 1 : m_el);
    n_ns  = (m_ph == 1 || nxt == 1) ? 1'b0 : (m_ns  | bus.ns_car);
    n_ew  = (m_ph == 3 || nxt == 3) ? 1'b0 : (m_ew  | bus.ew_car);
    n_ped = (m_ph == 5 || nxt == 5) ? 1'b0 : (m_ped | bus.ped_req);
    n_last_ew = (nxt == 3) ? 1'b1 : ((nxt == 1) ? 1'b0 : m_last_ew);
  endtask

  function automatic logic [6:0] lamps_for(int ph);
    logic ns_g = (ph == 1), ns_y = (ph == 2), ew_g = (ph == 3), ew_y = (ph == 4);
    return {!(ns_g || ns_y), ns_y, ns_g, !(ew_g || ew_y), ew_y, ew_g, ph == 5};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic exp_emg = bus.emg_req && ((m_ph == 1 && !bus.emg_dir) || (m_ph == 3 && bus.emg_dir));
    chk("phase", 8'(bus.phase), 8'(m_ph));
    chk("lamps", 8'({bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red,
                     bus.ew_yellow, bus.ew_green, bus.ped_walk}), 8'(lamps_for(m_ph)));
    chk("emg_active", 8'(bus.emg_active), 8'(exp_emg));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_ph = n_ph; m_el = n_el; m_ns = n_ns; m_ew = n_ew; m_ped = n_ped; m_last_ew = n_last_ew;
    check_all();
  endtask

  task automatic clear_inputs();
    bus.tick = 1'b1; bus.ns_car = 1'b0; bus.ew_car = 1'b0;
    bus.ped_req = 1'b0; bus.emg_req = 1'b0; bus.emg_dir = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_ph != ph && n < budget) begin step(); n++; end
    chk("wait_phase_reached", 8'(m_ph == ph), 8'd1);
  endtask

  task automatic measure(input int ph, input int expn, input string tag);
    int n = 0;
    do begin n++; step(); end while (m_ph == ph && n < 100);
    chk(tag, 8'(n), 8'(expn));
  endtask

  initial begin
    int seq[$];
    clear_inputs();
    model_reset();
    #1;
    chk("reset_phase", 8'(bus.phase), 8'd0);
    chk("reset_lamps", 8'({bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red,
                           bus.ew_yellow, bus.ew_green, bus.ped_walk}), 8'b1001000);

    // 1: idle cycling
    do_reset();
    repeat (6) seq.push_back(1);
    repeat (2) seq.push_back(2);
    seq.push_back(0);
    repeat (6) seq.push_back(3);
    repeat (2) seq.push_back(4);
    seq.push_back(0);
    seq.push_back(1);
    foreach (seq[i]) begin
      step();
      chk("idle_seq", 8'(bus.phase), 8'(seq[i]));
    end

    // 2: EW demand cuts NS green at GREEN_MIN
    do_reset();
    step();
    bus.ew_car = 1'b1;
    measure(1, 3, "ns_green_len_ewcar");
    measure(2, 2, "ns_yellow_len");
    measure(0, 1, "allred_len");
    chk("ew_green_after_demand", 8'(bus.phase), 8'd3);
    measure(3, 6, "ew_green_len_no_rival");
    bus.ew_car = 1'b0;

    // 3: pedestrian press, walk, dropped second press
    do_reset();
    step();
    step();
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    step();
    chk("ped_cuts_green", 8'(bus.phase), 8'd2);
    measure(2, 2, "ped_yellow_len");
    measure(0, 1, "ped_allred_len");
    chk("walk_entered", 8'(bus.phase), 8'd5);
    step();
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    step();
    step();
    chk("walk_to_ew", 8'(bus.phase), 8'd3);
    measure(3, 6, "no_extra_walk_demand");

    // 4: preemption toward EW from NS green
    do_reset();
    step();
    bus.emg_req = 1'b1;
    bus.emg_dir = 1'b1;
    step();
    chk("emg_yield_immediate", 8'(bus.phase), 8'd2);
    measure(2, 2, "emg_yellow_full");
    measure(0, 1, "emg_allred");
    chk("emg_green_ew", 8'(bus.phase), 8'd3);
    chk("emg_active_on", 8'(bus.emg_active), 8'd1);
    repeat (20) begin
      step();
      chk("emg_hold", 8'(bus.phase), 8'd3);
    end
    bus.emg_req = 1'b0;
    step();
    chk("emg_release_end", 8'(bus.phase), 8'd4);

    // 5: preemption aborts walk
    do_reset();
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    wait_phase(5, 40);
    step();
    bus.emg_req = 1'b1;
    bus.emg_dir = 1'b0;
    step();
    chk("walk_abort_phase", 8'(bus.phase), 8'd0);
    chk("walk_abort_walk", 8'(bus.ped_walk), 8'd0);
    step();
    chk("walk_abort_green", 8'(bus.phase), 8'd1);
    bus.emg_req = 1'b0;

    // 6: asynchronous reset during EW yellow with pending walk
    do_reset();
    wait_phase(4, 40);
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_phase", 8'(bus.phase), 8'd0);
    chk("async_reset_lamps", 8'({bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red,
                                 bus.ew_yellow, bus.ew_green, bus.ped_walk}), 8'b1001000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("post_reset_ns_first", 8'(bus.phase), 8'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      bus.tick    = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 15) bus.ns_car = ~bus.ns_car;
      if ($urandom_range(0, 99) < 15) bus.ew_car = ~bus.ew_car;
      bus.ped_req = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 3) begin
        bus.emg_req = ~bus.emg_req;
        if (bus.emg_req) bus.emg_dir = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
